// File: rtl/ahblite_interconnect_slaveport_arbiter.sv
// ---------------------------------------------------------------------------
// ahblite_interconnect_slaveport_arbiter
//
// Per-slave arbiter of the AHB-Lite crossbar. It picks which master port
// drives this slave's address phase. Arbitration is round-robin. A fixed-length
// burst or a locked sequence keeps the grant until it completes. The arbiter
// also records which master owns the current data phase, so the slave port can
// steer HWDATA, HRDATA and HREADYOUT.
//
// Parameters
//   MASTER  number of master ports (2..16)
//   PTR_W   width of the round-robin pointer ($clog2(MASTER))
//
// Ports
//   HCLK, HRESETn     clock, asynchronous active-low reset
//   mst_req_i         master i decodes this slave with HTRANS NONSEQ/SEQ
//   mst_HTRANS_i      per-master HTRANS
//   mst_HBURST_i      per-master HBURST
//   mst_HMASTLOCK_i   per-master HMASTLOCK
//   slv_HREADYOUT_i   slave ready; nothing advances while it is low
//   addr_grant_o      registered one-hot address-phase select (0 = IDLE)
//   data_owner_o      registered one-hot data-phase owner
//   data_valid_o      a NONSEQ/SEQ data phase is in flight
//   mst_wait_o        combinational stall per master (request not granted)
// ---------------------------------------------------------------------------

// Per-master slice: HTRANS activity decode and the stall output.
module ahblite_interconnect_slaveport_arbiter_lane (
    input  logic       req_i,
    input  logic [1:0] htrans_i,
    input  logic       grant_i,
    output logic       active_o,
    output logic       wait_o
);
    assign active_o = (htrans_i == 2'b10) || (htrans_i == 2'b11);
    assign wait_o   = req_i & ~grant_i;
endmodule

module ahblite_interconnect_slaveport_arbiter #(
    parameter int MASTER = 2,
    parameter int PTR_W  = $clog2(MASTER)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [MASTER-1:0]      mst_req_i,
    input  logic [MASTER-1:0][1:0] mst_HTRANS_i,
    input  logic [MASTER-1:0][2:0] mst_HBURST_i,
    input  logic [MASTER-1:0]      mst_HMASTLOCK_i,
    input  logic                   slv_HREADYOUT_i,
    output logic [MASTER-1:0]      addr_grant_o,
    output logic [MASTER-1:0]      data_owner_o,
    output logic                   data_valid_o,
    output logic [MASTER-1:0]      mst_wait_o
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;

    // Highest valid master index; the pointer wraps here, not at 2**PTR_W.
    localparam logic [PTR_W-1:0] LAST = PTR_W'(MASTER - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWNED,
        ST_BURST,
        ST_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;   // also the index of the current owner
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              first_q, first_d;     // burst granted, its NONSEQ not yet accepted
    logic [MASTER-1:0] grant_d;
    logic [MASTER-1:0] active;

    // -----------------------------------------------------------------------
    // Per-master lanes
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < MASTER; i++) begin : g_lane
        ahblite_interconnect_slaveport_arbiter_lane u_lane (
            .req_i    (mst_req_i[i]),
            .htrans_i (mst_HTRANS_i[i]),
            .grant_i  (addr_grant_o[i]),
            .active_o (active[i]),
            .wait_o   (mst_wait_o[i])
        );
    end

    // -----------------------------------------------------------------------
    // Current owner's command. It is only meaningful outside ST_IDLE.
    // -----------------------------------------------------------------------
    logic [1:0] own_trans;
    logic [2:0] own_burst;
    logic       own_lock;
    logic       own_req;

    assign own_trans = mst_HTRANS_i[rr_ptr_q];
    assign own_burst = mst_HBURST_i[rr_ptr_q];
    assign own_lock  = mst_HMASTLOCK_i[rr_ptr_q];
    assign own_req   = mst_req_i[rr_ptr_q];

    // -----------------------------------------------------------------------
    // Round-robin search. It starts one past the pointer and wraps. The
    // pointer slot itself is checked last, so the previous owner has the
    // lowest priority.
    // -----------------------------------------------------------------------
    logic             win_found;
    logic [PTR_W-1:0] win_idx;

    always_comb begin
        logic [PTR_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 0; k < MASTER; k++) begin
            cand = (cand == LAST) ? '0 : cand + PTR_W'(1);
            if (!win_found && mst_req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    logic [2:0] win_burst;
    logic       win_lock;
    logic       win_fixed;

    assign win_burst = mst_HBURST_i[win_idx];
    assign win_lock  = mst_HMASTLOCK_i[win_idx];
    assign win_fixed = win_burst[2] | win_burst[1];   // INCR4/WRAP4 and longer

    // Number of SEQ beats that follow the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] seq_beats(input logic [2:0] hb);
        case (hb)
            3'b010, 3'b011: seq_beats = 4'd3;
            3'b100, 3'b101: seq_beats = 4'd7;
            3'b110, 3'b111: seq_beats = 4'd15;
            default:        seq_beats = 4'd0;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Release detection. The result is only used when HREADYOUT is high.
    // -----------------------------------------------------------------------
    logic release_pt;

    always_comb begin
        release_pt = 1'b0;
        case (state_q)
            ST_IDLE:
                release_pt = 1'b1;
            ST_OWNED:
                release_pt = (own_trans == TR_IDLE) || !own_req ||
                             ((own_burst == HB_SINGLE) && (own_trans == TR_NONSEQ));
            ST_BURST:
                // Before the first beat is accepted, the owner's NONSEQ is
                // the burst start and not an early termination. The last
                // SEQ is the one that takes beat_cnt from 1 to 0.
                release_pt = (own_trans == TR_IDLE) ||
                             (!first_q && ((own_trans == TR_NONSEQ) ||
                                           ((own_trans == TR_SEQ) && (beat_cnt_q <= 4'd1))));
            ST_LOCKED:
                release_pt = !own_lock && (own_trans != TR_BUSY);
            default:
                release_pt = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        first_d    = first_q;
        grant_d    = addr_grant_o;

        if (slv_HREADYOUT_i) begin
            if (release_pt) begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    rr_ptr_d         = win_idx;
                    first_d          = 1'b1;
                    beat_cnt_d       = '0;
                    if (win_lock) begin
                        state_d = ST_LOCKED;
                    end else if (win_fixed) begin
                        state_d    = ST_BURST;
                        beat_cnt_d = seq_beats(win_burst);
                    end else begin
                        state_d = ST_OWNED;
                    end
                end else begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    first_d    = 1'b0;
                end
            end else if (state_q == ST_BURST) begin
                // BUSY leaves the count unchanged. The release check above
                // already handled the final SEQ, so beat_cnt >= 2 here.
                if (own_trans == TR_NONSEQ) begin
                    first_d = 1'b0;
                end else if (own_trans == TR_SEQ) begin
                    first_d    = 1'b0;
                    beat_cnt_d = beat_cnt_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= LAST;
            beat_cnt_q   <= '0;
            first_q      <= 1'b0;
            addr_grant_o <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            first_q      <= first_d;
            addr_grant_o <= grant_d;
        end
    end

    // -----------------------------------------------------------------------
    // Data-phase tracking: the accepted address phase becomes the data phase.
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_owner_o <= '0;
            data_valid_o <= 1'b0;
        end else if (slv_HREADYOUT_i) begin
            data_owner_o <= addr_grant_o;
            data_valid_o <= |(addr_grant_o & active);
        end
    end

endmodule

// File: tb/tb_ahblite_interconnect_slaveport_arbiter.sv
module tb_ahblite_interconnect_slaveport_arbiter;

    localparam logic [1:0] ID = 2'd0, BZ = 2'd1, NS = 2'd2, SQ = 2'd3;
    localparam logic [2:0] SG = 3'd0, IN = 3'd1, I4 = 3'd3, I8 = 3'd5;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    // Two-master DUT
    logic [1:0]      req, lock, grant, downer, wt;
    logic [1:0][1:0] trans;
    logic [1:0][2:0] burst;
    logic            rdy, dvalid;

    // Three-master DUT (non-power-of-two wrap)
    logic [2:0]      req3, lock3, grant3, downer3, wt3;
    logic [2:0][1:0] trans3;
    logic [2:0][2:0] burst3;
    logic            dvalid3;

    ahblite_interconnect_slaveport_arbiter #(.MASTER(2)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mst_req_i(req), .mst_HTRANS_i(trans), .mst_HBURST_i(burst),
        .mst_HMASTLOCK_i(lock), .slv_HREADYOUT_i(rdy),
        .addr_grant_o(grant), .data_owner_o(downer), .data_valid_o(dvalid),
        .mst_wait_o(wt)
    );

    ahblite_interconnect_slaveport_arbiter #(.MASTER(3)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mst_req_i(req3), .mst_HTRANS_i(trans3), .mst_HBURST_i(burst3),
        .mst_HMASTLOCK_i(lock3), .slv_HREADYOUT_i(rdy),
        .addr_grant_o(grant3), .data_owner_o(downer3), .data_valid_o(dvalid3),
        .mst_wait_o(wt3)
    );

    // One cycle of stimulus ({m1,m0} packing) and the expected state after the edge
    typedef struct {
        string      nm;
        logic [1:0] req;
        logic [3:0] tr;
        logic [5:0] hb;
        logic [1:0] lk;
        logic       rdy;
        logic [1:0] g;
        logic [1:0] dow;
        logic       dv;
    } vec_t;

    typedef struct {
        string      nm;
        logic [1:0] g;
        logic [1:0] dow;
        logic       dv;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    logic [1:0] exp_g = 2'b00;   // expected grant currently on the bus

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [1:0] rq, input logic [3:0] tr,
                                input logic [5:0] hb, input logic [1:0] lk, input logic rd,
                                input logic [1:0] g, input logic [1:0] dw, input logic dv);
        vec_t v;
        v.nm = nm; v.req = rq; v.tr = tr; v.hb = hb; v.lk = lk; v.rdy = rd;
        v.g = g; v.dow = dw; v.dv = dv;
        return v;
    endfunction

    task automatic run_row(input vec_t v);
        exp_t e;
        @(negedge HCLK);
        req = v.req; trans = v.tr; burst = v.hb; lock = v.lk; rdy = v.rdy;
        e.nm = v.nm; e.g = v.g; e.dow = v.dow; e.dv = v.dv;
        sb.push_back(e);
        #1 chk($sformatf("%s.wait", v.nm), 32'(wt), 32'(v.req & ~exp_g));
        @(posedge HCLK);
        #1;
        e = sb.pop_front();
        chk($sformatf("%s.grant", e.nm), 32'(grant), 32'(e.g));
        chk($sformatf("%s.downer", e.nm), 32'(downer), 32'(e.dow));
        chk($sformatf("%s.dvalid", e.nm), 32'(dvalid), 32'(e.dv));
        exp_g = e.g;
    endtask

    logic [2:0] r3 [6];
    logic [2:0] e3 [6];

    initial begin
        HRESETn = 1'b0;
        req = 2'b11; trans = '0; burst = '0; lock = '0; rdy = 1'b1;
        req3 = '0; trans3 = '0; burst3 = '0; lock3 = '0;

        // Single master: SINGLE is re-granted while held, then released on IDLE
        vt.push_back(mk("A1", 2'b01, {ID,NS}, {SG,SG}, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0));
        vt.push_back(mk("A2", 2'b01, {ID,NS}, {SG,SG}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        vt.push_back(mk("A3", 2'b00, {ID,ID}, {SG,SG}, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0));
        vt.push_back(mk("A4", 2'b00, {ID,ID}, {SG,SG}, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));
        // Round-robin with back-to-back SINGLEs (pointer left at M0)
        vt.push_back(mk("B1", 2'b11, {NS,NS}, {SG,SG}, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0));
        vt.push_back(mk("B2", 2'b11, {NS,NS}, {SG,SG}, 2'b00, 1'b1, 2'b01, 2'b10, 1'b1));
        vt.push_back(mk("B3", 2'b11, {NS,NS}, {SG,SG}, 2'b00, 1'b1, 2'b10, 2'b01, 1'b1));
        vt.push_back(mk("B4", 2'b11, {NS,NS}, {SG,SG}, 2'b00, 1'b1, 2'b01, 2'b10, 1'b1));
        vt.push_back(mk("B5", 2'b00, {ID,ID}, {SG,SG}, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0));
        // INCR4 with BUSY and wait states while M1 requests
        vt.push_back(mk("C1",  2'b01, {ID,NS}, {SG,I4}, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0));
        vt.push_back(mk("C2",  2'b11, {NS,NS}, {SG,I4}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        vt.push_back(mk("C3",  2'b11, {NS,SQ}, {SG,I4}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        vt.push_back(mk("C4",  2'b10, {NS,BZ}, {SG,I4}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0));
        vt.push_back(mk("C5",  2'b11, {NS,SQ}, {SG,I4}, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0));
        vt.push_back(mk("C6",  2'b11, {NS,SQ}, {SG,I4}, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0));
        vt.push_back(mk("C7",  2'b11, {NS,SQ}, {SG,I4}, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0));
        vt.push_back(mk("C8",  2'b11, {NS,SQ}, {SG,I4}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        vt.push_back(mk("C9",  2'b11, {NS,SQ}, {SG,I4}, 2'b00, 1'b1, 2'b10, 2'b01, 1'b1));
        vt.push_back(mk("C10", 2'b10, {NS,ID}, {SG,SG}, 2'b00, 1'b1, 2'b10, 2'b10, 1'b1));
        vt.push_back(mk("C11", 2'b00, {ID,ID}, {SG,SG}, 2'b00, 1'b1, 2'b00, 2'b10, 1'b0));
        // M1 locked across two INCR bursts
        vt.push_back(mk("D1", 2'b10, {NS,ID}, {IN,SG}, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0));
        vt.push_back(mk("D2", 2'b11, {NS,NS}, {IN,SG}, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1));
        vt.push_back(mk("D3", 2'b11, {SQ,NS}, {IN,SG}, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1));
        vt.push_back(mk("D4", 2'b01, {ID,NS}, {IN,SG}, 2'b10, 1'b1, 2'b10, 2'b10, 1'b0));
        vt.push_back(mk("D5", 2'b11, {NS,NS}, {IN,SG}, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1));
        vt.push_back(mk("D6", 2'b11, {SQ,NS}, {IN,SG}, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1));
        vt.push_back(mk("D7", 2'b01, {ID,NS}, {IN,SG}, 2'b00, 1'b1, 2'b01, 2'b10, 1'b0));
        vt.push_back(mk("D8", 2'b01, {ID,NS}, {IN,SG}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        vt.push_back(mk("D9", 2'b00, {ID,ID}, {SG,SG}, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0));
        // INCR8 terminated with IDLE after 3 beats
        vt.push_back(mk("E1", 2'b01, {ID,NS}, {SG,I8}, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0));
        vt.push_back(mk("E2", 2'b01, {ID,NS}, {SG,I8}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        vt.push_back(mk("E3", 2'b01, {ID,SQ}, {SG,I8}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        vt.push_back(mk("E4", 2'b01, {ID,SQ}, {SG,I8}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        vt.push_back(mk("E5", 2'b00, {ID,ID}, {SG,I8}, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0));
        vt.push_back(mk("E6", 2'b00, {ID,ID}, {SG,SG}, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));

        // Reset state
        #12;
        chk("rst.grant",  32'(grant),  32'd0);
        chk("rst.downer", 32'(downer), 32'd0);
        chk("rst.dvalid", 32'(dvalid), 32'd0);
        chk("rst.wait",   32'(wt),     32'(2'b11));
        chk("rst.grant3", 32'(grant3), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1; req = '0;

        foreach (vt[i]) run_row(vt[i]);

        // Asynchronous reset in the middle of an INCR8
        run_row(mk("F1", 2'b01, {ID,NS}, {SG,I8}, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0));
        run_row(mk("F2", 2'b01, {ID,NS}, {SG,I8}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        run_row(mk("F3", 2'b01, {ID,SQ}, {SG,I8}, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1));
        #2 HRESETn = 1'b0;
        #1;
        chk("arst.grant",  32'(grant),  32'd0);
        chk("arst.downer", 32'(downer), 32'd0);
        chk("arst.dvalid", 32'(dvalid), 32'd0);
        chk("arst.wait",   32'(wt),     32'(2'b01));
        req = '0; trans = '0; burst = '0;
        exp_g = 2'b00;
        @(negedge HCLK);
        HRESETn = 1'b1;
        run_row(mk("R1", 2'b11, {NS,NS}, {SG,SG}, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0));
        run_row(mk("R2", 2'b00, {ID,ID}, {SG,SG}, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0));

        // Three masters: the pointer wraps at index 2
        r3 = '{3'b111, 3'b111, 3'b111, 3'b100, 3'b111, 3'b000};
        e3 = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001, 3'b000};
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            req3 = r3[i];
            for (int j = 0; j < 3; j++) trans3[j] = r3[i][j] ? NS : ID;
            @(posedge HCLK);
            #1 chk($sformatf("G%0d.grant3", i + 1), 32'(grant3), 32'(e3[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ahblite_interconnect_slaveport_arbiter.md
# ahblite_interconnect_slaveport_arbiter

Per-slave arbiter of the AHB-Lite interconnect. It sits on the slave side of the crossbar and receives the address-decoded select from every master port. It grants the slave's address phase to one master at a time, round-robin, and never splits a fixed-length burst or a locked sequence. It also tracks the data-phase owner so the slave port can steer HWDATA, HRDATA and HREADYOUT.

## Interface
Parameters:
- MASTER, 2: number of master ports arbitrating for this slave (2..16).
- PTR_W, $clog2(MASTER): width of the round-robin pointer.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- mst_req_i  in  [MASTER-1:0]  master i decodes this slave and drives HTRANS NONSEQ/SEQ (held by the master port while waiting).
- mst_HTRANS_i  in  [MASTER-1:0][1:0]  per-master HTRANS.
- mst_HBURST_i  in  [MASTER-1:0][2:0]  per-master HBURST.
- mst_HMASTLOCK_i  in  [MASTER-1:0]  per-master HMASTLOCK.
- slv_HREADYOUT_i  in  1  slave HREADYOUT; transfers advance only when it is 1.
- addr_grant_o  out  [MASTER-1:0]  one-hot (or zero) address-phase mux select, registered. All-zero means the slave port drives HTRANS=IDLE.
- data_owner_o  out  [MASTER-1:0]  one-hot (or zero) data-phase owner, registered.
- data_valid_o  out  1  a NONSEQ/SEQ data phase is in progress with the slave.
- mst_wait_o  out  [MASTER-1:0]  combinational: mst_req_i[i] & ~addr_grant_o[i]. The master port stalls its master and holds its command.

## Operation
- States:
  - IDLE: no grant.
  - OWNED: grant held by one master, single transfer or undefined-length INCR.
  - BURST: fixed-length burst in progress, beat counter active.
  - LOCKED: HMASTLOCK asserted by the owner.
- Arbitration runs only when the grant is free (IDLE, or OWNED/BURST at a release point) and slv_HREADYOUT_i=1.
  - Search starts at rr_ptr+1 and wraps modulo MASTER. The first set mst_req_i bit wins.
  - rr_ptr is then loaded with the winner's index.
  - No request: go to IDLE, grant all-zero.
- Entry state after a grant:
  - Winner's HMASTLOCK=1 → LOCKED.
  - Else HBURST in {INCR4, WRAP4, INCR8, WRAP8, INCR16, WRAP16} → BURST, with beat_cnt loaded to 4/8/16 minus 1.
  - Else → OWNED.
- Beat accounting (BURST): each cycle with slv_HREADYOUT_i=1 and owner HTRANS=SEQ decrements beat_cnt. BUSY and HREADYOUT=0 freeze it.
- Release points (all require slv_HREADYOUT_i=1):
  - OWNED: owner HTRANS=IDLE, or mst_req_i[owner]=0, or HBURST=SINGLE with NONSEQ accepted.
  - BURST: beat_cnt=0 with the final SEQ accepted, or early termination (owner HTRANS=IDLE or NONSEQ).
  - LOCKED: owner HMASTLOCK=0 and HTRANS≠BUSY.
- At a release point, re-arbitration happens in the same cycle. The grant moves A→B at one edge with no idle address phase.
- Data-phase tracking, on each edge where slv_HREADYOUT_i=1:
  - data_owner_o <= addr_grant_o.
  - data_valid_o <= |(addr_grant_o & {NONSEQ or SEQ on the granted HTRANS}).
  - When slv_HREADYOUT_i=0, both hold.
- Widths: beat_cnt is 4 bits; rr_ptr is PTR_W bits, and the wrap compare is against MASTER-1 (non-power-of-two MASTER is legal).

## Timing
- Reset values: addr_grant_o=0, data_owner_o=0, data_valid_o=0, state=IDLE, rr_ptr=MASTER-1 (master 0 wins first), beat_cnt=0. mst_wait_o=mst_req_i during reset.
- Request latency: a request first seen at edge N (HREADYOUT=1) gives addr_grant_o at N+1. The address phase completes at N+1 when HREADYOUT=1, and data_owner_o follows at N+2.
- A request arriving while HREADYOUT=0 waits. Grant never changes while slv_HREADYOUT_i=0.
- A simultaneous request from the current owner and others at a release point: the owner is lowest priority (round-robin).
- Reset mid-burst: all outputs clear immediately (asynchronous). After reset, the first arbitration follows normal latency.

## Test plan
- Single master: M0 req, SINGLE NONSEQ, HREADYOUT=1 → addr_grant_o=01 one cycle after req, data_owner_o=01 and data_valid_o=1 next cycle, then grant 00.
- Round-robin: M0 and M1 both request continuous SINGLEs → grants alternate 01,10,01,10 with no gap cycles; mst_wait_o set on the loser each cycle.
- Burst hold: M0 INCR4 while M1 requests → grant stays 01 for 4 accepted beats. A BUSY inserted after beat 2 and HREADYOUT=0 for 3 cycles do not advance beat_cnt. M1 is granted at the edge after beat 4 is accepted.
- Lock: M1 HMASTLOCK=1 across two INCR bursts with M0 requesting → M0 is never granted until M1 drops HMASTLOCK. Then M0 is granted at the next edge.
- Early termination and reset: M0 INCR8 drives IDLE after 3 beats → grant released that edge. Asserting HRESETn=0 mid-burst clears addr_grant_o, data_owner_o and data_valid_o immediately; after release, M0 wins first.
